// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory port, redirect input from
// execute, and the valid/ready instruction stream to decode.
//   imem_addr      : fetch -> imem, byte address (current fetch PC)
//   imem_rdata     : imem -> fetch, combinational instruction word
//   redirect_valid : execute -> fetch, take redirect this cycle
//   redirect_pc    : execute -> fetch, redirect target byte address
//   out_valid      : fetch -> decode, head entry valid
//   out_ready      : decode -> fetch, head accepted
//   out_pc         : fetch -> decode, PC of head entry
//   out_instr      : fetch -> decode, instruction of head entry
//   misalign_fault : fetch -> core, sticky misaligned-redirect flag
interface fetch_unit_if;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        misalign_fault;

    // Fetch unit side
    modport master (
        output imem_addr,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output out_valid,
        input  out_ready,
        output out_pc,
        output out_instr,
        output misalign_fault
    );

    // Memory / execute / decode side
    modport slave (
        input  imem_addr,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  out_valid,
        output out_ready,
        input  out_pc,
        input  out_instr,
        input  misalign_fault
    );
endinterface

// File: rtl/fetch_unit.sv
// PC and prefetch stage of the RV32I core. Owns the fetch PC, drives it to
// instruction memory, captures the returned word together with its PC into
// a DEPTH-entry FIFO and presents the head to decode via valid/ready.
// Redirects flush the FIFO and restart fetch at the target.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN
//   defined   : misaligned redirect sets sticky misalign_fault and halts fetch
//   undefined : redirect_pc[1:0] forced to 0, misalign_fault tied 0
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : fetch_unit_if.master (imem port, redirect, decode stream, fault)
// Parameters:
//   RESET_PC : fetch PC after reset
//   DEPTH    : FIFO entries (>= 2)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W  = 64;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic {RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic               push_c;
    logic               pop_c;
    logic               valid_c;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic               fault_q, fault_d;
`endif

    // Pointer increment modulo DEPTH (DEPTH need not be a power of two)
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign valid_c = (cnt_q != '0);
    assign pop_c   = valid_c && bus.out_ready;

    // Next-state: redirect wins over push/pop; HALT blocks fetching
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        cnt_d      = cnt_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        push_c     = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q;
`endif
        if (bus.redirect_valid) begin
            cnt_d = '0;
            rd_d  = '0;
            wr_d  = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fetch_pc_d = bus.redirect_pc;
            if (bus.redirect_pc[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = HALT;
            end else begin
                fault_d = 1'b0;
                state_d = RUN;
            end
`else
            fetch_pc_d = bus.redirect_pc & 32'hFFFF_FFFC;
            state_d    = RUN;
`endif
        end else begin
            case (state_q)
                RUN:     push_c = (cnt_q < CNT_W'(DEPTH)) || pop_c;
                HALT:    push_c = 1'b0;
                default: push_c = 1'b0;
            endcase
            if (push_c) begin
                wr_d       = ptr_inc(wr_q);
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop_c) begin
                rd_d = ptr_inc(rd_q);
            end
            case ({push_c, pop_c})
                2'b10:   cnt_d = cnt_q + CNT_W'(1);
                2'b01:   cnt_d = cnt_q - CNT_W'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            cnt_q      <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            cnt_q      <= cnt_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
        end
    end

    // FIFO storage; contents are don't-care while count is 0
    always_ff @(posedge clk) begin
        if (push_c && !rst) begin
            mem_q[wr_q] <= {fetch_pc_q, bus.imem_rdata};
        end
    end

    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = valid_c;
    assign bus.out_pc    = valid_c ? mem_q[rd_q][63:32] : 32'h0000_0000;
    assign bus.out_instr = valid_c ? mem_q[rd_q][31:0]  : NOP;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.misalign_fault = fault_q;
`else
    assign bus.misalign_fault = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Table-driven bench for fetch_unit (DEPTH=2, RESET_PC=0) plus a hand
// sequence for asynchronous reset between clock edges.
module tb_fetch_unit;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    fetch_unit_if fif();

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (fif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory: two fixed words, address-derived pattern elsewhere
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0004: return 32'h00A0_0113;
            default:       return a ^ 32'hDEAD_0000;
        endcase
    endfunction

    always_comb fif.imem_rdata = imem_word(fif.imem_addr);

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        rdy;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einstr;
        logic [31:0] eaddr;
        logic        efault;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic rv, input logic [31:0] rpc,
                                input logic rdy, input logic ev, input logic [31:0] epc,
                                input logic [31:0] ei, input logic [31:0] ea,
                                input logic ef);
        vec_t v;
        v.rst = r; v.rv = rv; v.rpc = rpc; v.rdy = rdy; v.ev = ev;
        v.epc = epc; v.einstr = ei; v.eaddr = ea; v.efault = ef;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic ev, input logic [31:0] epc,
                             input logic [31:0] ei, input logic [31:0] ea, input logic ef);
        check({tag, " out_valid"},      32'(fif.out_valid),      32'(ev));
        check({tag, " out_pc"},         fif.out_pc,              epc);
        check({tag, " out_instr"},      fif.out_instr,           ei);
        check({tag, " imem_addr"},      fif.imem_addr,           ea);
        check({tag, " misalign_fault"}, 32'(fif.misalign_fault), 32'(ef));
    endtask

    localparam logic [31:0] NOP = 32'h0000_0013;

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1;
        fif.redirect_valid = 1'b0;
        fif.redirect_pc    = 32'h0;
        fif.out_ready      = 1'b0;

        //                rst  rv  rpc            rdy ev  epc            instr          addr           fault
        // reset, then streaming with ready high
        vecs.push_back(mk(1, 0, 32'h0,          1, 0, 32'h0,         NOP,           32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0,         32'h0050_0093, 32'h4,         0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h4,         32'h00A0_0113, 32'h8,         0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h8,         32'hDEAD_0008, 32'hC,         0));
        // reset, then ready low for 5 cycles: fills to 2, fetch holds at 0x8
        vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,         NOP,           32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h0,         32'h0050_0093, 32'h4,         0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 32'h0,      0, 1, 32'h0,         32'h0050_0093, 32'h8,         0));
        // release: pop+push on full FIFO keeps it full
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h4,         32'h00A0_0113, 32'hC,         0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h8,         32'hDEAD_0008, 32'h10,        0));
        // redirect to 0x40 while full and handshaking
        vecs.push_back(mk(0, 1, 32'h40,         1, 0, 32'h0,         NOP,           32'h40,        0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h40,        32'hDEAD_0040, 32'h44,        0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h44,        32'hDEAD_0044, 32'h48,        0));
        // PC wrap-around
        vecs.push_back(mk(0, 1, 32'hFFFF_FFFC,  1, 0, 32'h0,         NOP,           32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'hFFFF_FFFC, 32'h2152_FFFC, 32'h0,         0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h0,         32'h0050_0093, 32'h4,         0));
`ifdef FETCH_MISALIGN_TRAP_EN
        // misaligned redirect halts with sticky fault; aligned redirect resumes
        vecs.push_back(mk(0, 1, 32'h102,        1, 0, 32'h0,         NOP,           32'h102,       1));
        for (int i = 0; i < 10; i++)
            vecs.push_back(mk(0, 0, 32'h0,      1, 0, 32'h0,         NOP,           32'h102,       1));
        vecs.push_back(mk(0, 1, 32'h100,        1, 0, 32'h0,         NOP,           32'h100,       0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h100,       32'hDEAD_0100, 32'h104,       0));
`else
        // misaligned redirect is silently aligned
        vecs.push_back(mk(0, 1, 32'h102,        1, 0, 32'h0,         NOP,           32'h100,       0));
        vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h100,       32'hDEAD_0100, 32'h104,       0));
`endif

        foreach (vecs[i]) begin
            rst                = vecs[i].rst;
            fif.redirect_valid = vecs[i].rv;
            fif.redirect_pc    = vecs[i].rpc;
            fif.out_ready      = vecs[i].rdy;
            @(posedge clk);
            #1;
            check_all($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc,
                      vecs[i].einstr, vecs[i].eaddr, vecs[i].efault);
        end
        rst                = 1'b0;
        fif.redirect_valid = 1'b0;
        fif.out_ready      = 1'b1;

        // Stream a little further, then assert reset between edges
        @(posedge clk);
        #1;
        check_all("pre_async", 1'b1, 32'h104, 32'hDEAD_0104, 32'h108, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_all("async_rst", 1'b0, 32'h0, NOP, 32'h0, 1'b0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_all("resume0", 1'b1, 32'h0, 32'h0050_0093, 32'h4, 1'b0);
        @(posedge clk);
        #1;
        check_all("resume1", 1'b1, 32'h4, 32'h00A0_0113, 32'h8, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Program-counter and prefetch stage of the single-cycle RV32I core. It owns the fetch PC, drives the byte address into the instruction memory, and captures the combinationally returned word. Captured words are buffered with their PC in a small FIFO and handed to decode over a valid/ready handshake. Branch and jump redirects from execute flush the buffer and restart fetch at the target.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC loaded on reset.
- `DEPTH`, default 2: prefetch FIFO entries; any integer ≥ 2.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: reset, asynchronous and active-high.
- `imem_addr`  out  32: byte address to instruction memory; equals fetch PC.
- `imem_rdata`  in  32: instruction word; combinational function of `imem_addr`.
- `redirect_valid`  in  1: take redirect this cycle.
- `redirect_pc`  in  32: redirect target byte address.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: decode accepts head.
- `out_pc`  out  32: PC of head entry.
- `out_instr`  out  32: instruction of head entry.
- `misalign_fault`  out  1: sticky misaligned-redirect flag (see Configuration).

## Operation
- State: `fetch_pc` (32 b), FIFO of DEPTH × {pc, instr}, read/write pointers modulo DEPTH, count 0..DEPTH, FSM {RUN, HALT}.
- `imem_addr = fetch_pc` combinationally in all states.
- pop = `out_valid && out_ready`.
- push (RUN only, no redirect) = `count < DEPTH || pop`. On push, write {fetch_pc, imem_rdata} at the write pointer and set `fetch_pc <= fetch_pc + 4`.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Simultaneous push and pop on a full FIFO is allowed; count is unchanged.
- Redirect has the highest priority:
  - count is set to 0 and pointers are reset.
  - `fetch_pc <= redirect_pc`; FSM goes to RUN.
  - Any push or pop in the same cycle is discarded, including a handshake decode saw as accepted. Decode must treat a same-cycle redirect as squashing it.
- `out_valid = (count != 0)`.
- `out_pc` / `out_instr` show the head entry. When empty they are forced to 32'h0 / 32'h0000_0013 (NOP).
- `out_pc` / `out_instr` are held stable while `out_valid && !out_ready`.
- FSM:
  - RUN → HALT only on a faulting redirect (macro builds only).
  - HALT → RUN on a non-faulting redirect.
  - In HALT: no push, FIFO empty, `fetch_pc` unchanged.
- Reset values: `fetch_pc = RESET_PC`, count 0, FSM RUN, `out_valid` 0, `out_pc` 0, `out_instr` 32'h13, `misalign_fault` 0, `imem_addr = RESET_PC`.

## Timing
- Fetch-to-output latency is 1 cycle. A word pushed at edge N is visible on `out_*` after edge N.
- First `out_valid` rises after the first rising edge following `rst` deassertion, with `out_pc = RESET_PC`.
- Redirect asserted in cycle N:
  - `out_valid` is 0 in cycle N+1 (the cycle after the redirect edge).
  - The target instruction is presented in N+2.
- Sustained throughput is 1 instruction per cycle with `out_ready` held high.
- With `out_ready` low, fetch stops after DEPTH pushes. `fetch_pc` then holds at the next unfetched address.
- `rst` assertion mid-operation clears everything immediately (asynchronously), regardless of clock.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined:
  - A redirect with `redirect_pc[1:0] != 0` flushes the FIFO and sets `misalign_fault` (sticky).
  - `fetch_pc` loads the raw target and the FSM enters HALT.
  - `misalign_fault` clears on reset or on an aligned redirect.
- Not defined:
  - `redirect_pc[1:0]` is forced to 2'b00 on load.
  - `misalign_fault` is tied 0 and HALT is unreachable.

## Test plan
- Reset release, `out_ready`=1, IMEM holds 0x00500093, 0x00A00113 at words 0,1 → `out_pc` 0x0 then 0x4 on consecutive cycles; `out_instr` matches each word.
- Hold `out_ready`=0 for 5 cycles with DEPTH=2 → count saturates at 2 and `imem_addr` holds 0x8. Head stays pc 0x0 / 0x00500093.
- Redirect to 0x40 while the FIFO is full and `out_ready`=1 → next cycle `out_valid`=0. The following cycle `out_pc`=0x40; no pre-redirect entry ever reappears.
- Redirect to 0xFFFF_FFFC → presented PCs are 0xFFFF_FFFC then 0x0000_0000.
- With `FETCH_MISALIGN_TRAP_EN`: redirect to 0x102 → `misalign_fault`=1 and `out_valid` stays 0 for 10 cycles. Redirect to 0x100 → fault clears and `out_pc`=0x100 two cycles later. Without the macro, the same 0x102 redirect yields `out_pc`=0x100 and no fault.
- Assert `rst` asynchronously mid-stream between edges → all outputs take reset values immediately. Fetch resumes at `RESET_PC` after release.
